// File: rtl/show_sw_display_if.sv
// Board I/O bundle for show_sw_display: switch bank in, 7-segment and LED lines out.
// master = board/stimulus side, slave = show_sw_display.
interface show_sw_display_if;
  localparam int unsigned SW_W  = 4;
  localparam int unsigned CS_W  = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned LED_W = 4;

  logic [SW_W-1:0]  switch;   // active-low switches
  logic [CS_W-1:0]  num_csn;  // active-low digit selects
  logic [SEG_W-1:0] num_a_g;  // active-high segments, bit6=a .. bit0=g
  logic [LED_W-1:0] led;      // active-low LEDs

  modport master (output switch, input num_csn, num_a_g, led);
  modport slave  (input switch, output num_csn, num_a_g, led);
endinterface

// File: rtl/show_sw_display.sv
// show_sw_display: shows the inverted switch value as a hex digit on one
// 7-segment digit and the value held before the latest change on the LEDs.
// Optional macro SHOW_SW_DUAL_DIGIT_EN: time-multiplexes a second digit
// (DIGIT_SEL-1 mod 8) showing the previous value, driven by a SCAN_BITS counter.
module show_sw_display #(
  parameter int unsigned DIGIT_SEL = 7,
  parameter int unsigned SCAN_BITS = 16
) (
  input  logic               clk,
  input  logic               resetn,
  show_sw_display_if.slave   io
);

  localparam int unsigned VAL_W = 4;
  localparam int unsigned CS_W  = 8;
  localparam int unsigned SEG_W = 7;

  localparam int unsigned DIGIT_MAIN = DIGIT_SEL % CS_W;
  localparam int unsigned DIGIT_ALT  = (DIGIT_SEL + CS_W - 1) % CS_W;
  localparam logic [CS_W-1:0] CSN_MAIN = ~(CS_W'(1) << DIGIT_MAIN);
  localparam logic [CS_W-1:0] CSN_ALT  = ~(CS_W'(1) << DIGIT_ALT);

  logic [VAL_W-1:0] show_data;
  logic [VAL_W-1:0] show_data_r;
  logic [VAL_W-1:0] prev_data;
  logic [VAL_W-1:0] disp_data;
  logic [CS_W-1:0]  csn_next;

  // Hex digit to segment pattern (bit6=a .. bit0=g).
  function automatic logic [SEG_W-1:0] hex_seg(input logic [VAL_W-1:0] v);
    logic [SEG_W-1:0] seg;
    case (v)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  // Sample the active-low switches and keep a one-cycle delayed copy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      show_data   <= '0;
      show_data_r <= '0;
    end else begin
      show_data   <= ~io.switch;
      show_data_r <= show_data;
    end
  end

  // Capture the value that was current just before each change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_data <= '0;
    end else if (show_data != show_data_r) begin
      prev_data <= show_data_r;
    end
  end

  // LEDs are active-low copies of the previous value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      io.led <= '1;
    end else begin
      io.led <= ~prev_data;
    end
  end

`ifdef SHOW_SW_DUAL_DIGIT_EN
  logic [SCAN_BITS-1:0] scan_cnt;
  logic                 scan_phase;

  assign scan_phase = scan_cnt[SCAN_BITS-1];

  // Free-running scan counter; its MSB picks which digit is lit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_BITS'(1);
    end
  end

  // Phase 0 shows the current value, phase 1 the previous one on the neighbour digit.
  always_comb begin
    disp_data = show_data;
    csn_next  = CSN_MAIN;
    if (scan_phase) begin
      disp_data = prev_data;
      csn_next  = CSN_ALT;
    end
  end
`else
  // Single digit always showing the current value.
  always_comb begin
    disp_data = show_data;
    csn_next  = CSN_MAIN;
  end

  // The scan width only matters in the dual-digit build.
  if (SCAN_BITS == 0) begin : g_scan_unused
  end
`endif

  // Registered digit select and segment drive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      io.num_csn <= '1;
      io.num_a_g <= '0;
    end else begin
      io.num_csn <= csn_next;
      io.num_a_g <= hex_seg(disp_data);
    end
  end

endmodule

// File: tb/tb_show_sw_display.sv
// Directed bench for show_sw_display (default single-digit build).
module tb_show_sw_display;

  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;

  show_sw_display_if io ();

  show_sw_display #(.DIGIT_SEL(7), .SCAN_BITS(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] seq_sw  [4] = '{4'h9, 4'hE, 4'h2, 4'h0};
  logic [6:0] seq_seg [4] = '{7'h5F, 7'h30, 7'h3D, 7'h47};
  logic [3:0] seq_led [4] = '{4'h8, 4'h9, 4'hE, 4'h2};

  initial begin
    logic [3:0] led_before;
    n_pass  = 0;
    n_total = 0;
    resetn    = 1'b0;
    io.switch = 4'hF;

    // Long reset with all switches released.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i % 20 == 0) begin
        check("rst_csn", io.num_csn, 8'hFF);
        check("rst_seg", {1'b0, io.num_a_g}, 8'h00);
        check("rst_led", {4'h0, io.led}, 8'h0F);
      end
    end

    // Release with value 0.
    resetn = 1'b1;
    wait_clks(2);
    check("rel_csn", io.num_csn, 8'h7F);
    check("rel_seg", {1'b0, io.num_a_g}, 8'h7E);
    check("rel_led", {4'h0, io.led}, 8'h0F);

    // F -> 8 (value 7): segments after 2 clk, LED stays F.
    io.switch = 4'h8;
    wait_clks(1);
    check("v7_seg_early", {1'b0, io.num_a_g}, 8'h7E);
    wait_clks(1);
    check("v7_seg", {1'b0, io.num_a_g}, 8'h70);
    wait_clks(2);
    check("v7_led", {4'h0, io.led}, 8'h0F);
    wait_clks(6);

    // Sequence 9, E, 2, 0 each held 10 cycles.
    led_before = 4'hF;
    for (int k = 0; k < 4; k++) begin
      io.switch = seq_sw[k];
      wait_clks(2);
      check("seq_seg", {1'b0, io.num_a_g}, {1'b0, seq_seg[k]});
      check("seq_led_hold", {4'h0, io.led}, {4'h0, led_before});
      wait_clks(2);
      check("seq_led", {4'h0, io.led}, {4'h0, seq_led[k]});
      wait_clks(6);
      check("seq_led_stable", {4'h0, io.led}, {4'h0, seq_led[k]});
      check("seq_seg_stable", {1'b0, io.num_a_g}, {1'b0, seq_seg[k]});
      led_before = seq_led[k];
    end

    // Back-to-back changes 8 -> 9 -> 8 (values 7, 6, 7).
    io.switch = 4'h8;
    wait_clks(1);
    io.switch = 4'h9;
    wait_clks(1);
    io.switch = 4'h8;
    check("fast_seg_n2", {1'b0, io.num_a_g}, 8'h70);
    check("fast_led_n2", {4'h0, io.led}, 8'h02);
    wait_clks(1);
    check("fast_seg_n3", {1'b0, io.num_a_g}, 8'h5F);
    check("fast_led_n3", {4'h0, io.led}, 8'h00);
    wait_clks(1);
    check("fast_seg_n4", {1'b0, io.num_a_g}, 8'h70);
    check("fast_led_n4", {4'h0, io.led}, 8'h08);
    wait_clks(1);
    check("fast_led_n5", {4'h0, io.led}, 8'h09);
    wait_clks(10);
    check("fast_led_final", {4'h0, io.led}, 8'h09);

    // Asynchronous reset mid-run, away from the clock edge.
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_csn", io.num_csn, 8'hFF);
    check("mid_rst_seg", {1'b0, io.num_a_g}, 8'h00);
    check("mid_rst_led", {4'h0, io.led}, 8'h0F);
    wait_clks(3);
    check("mid_rst_hold_seg", {1'b0, io.num_a_g}, 8'h00);
    resetn = 1'b1;
    wait_clks(2);
    check("post_rst_csn", io.num_csn, 8'h7F);
    check("post_rst_seg", {1'b0, io.num_a_g}, 8'h70);
    wait_clks(4);
    check("post_rst_led", {4'h0, io.led}, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
